// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the writeback stage.
// Holds the thread-count constants, the thread-control opcodes
// and the writeback FSM state type.
package wb_stage_pkg;

    localparam int unsigned NUM_TRD  = 8;
    localparam int unsigned TRD_W    = 3;
    localparam int unsigned BOOT_TRD = 0;

    typedef enum logic [1:0] {
        TC_NONE  = 2'b00,
        TC_SPAWN = 2'b01,
        TC_KILL  = 2'b10,
        TC_HALT  = 2'b11
    } trd_ctrl_t;

    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_trd_table.sv
// Thread-activity table plus the spawn-pulse registers.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   op            thread-control opcode (TC_NONE when nothing qualifies)
//   obj           target thread for spawn/kill
//   self          issuing thread, used by halt
//   pc            start PC for a spawned thread
//   trd_active    activity mask, BOOT_TRD set out of reset
//   trd_start     one-cycle pulse after a successful spawn
//   trd_start_id  spawned thread id, held until the next spawn
//   trd_start_pc  spawned thread PC, held until the next spawn
module wb_stage_trd_table
    import wb_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  trd_ctrl_t          op,
    input  logic [TRD_W-1:0]   obj,
    input  logic [TRD_W-1:0]   self,
    input  logic [31:0]        pc,
    output logic [NUM_TRD-1:0] trd_active,
    output logic               trd_start,
    output logic [TRD_W-1:0]   trd_start_id,
    output logic [31:0]        trd_start_pc
);

    localparam logic [TRD_W-1:0] BOOT_ID = TRD_W'(BOOT_TRD);

    // Mask update and spawn pulse; the boot thread can never be cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trd_active   <= NUM_TRD'(1) << BOOT_TRD;
            trd_start    <= 1'b0;
            trd_start_id <= '0;
            trd_start_pc <= '0;
        end else begin
            trd_start <= 1'b0;
            case (op)
                TC_SPAWN: begin
                    if (!trd_active[obj]) begin
                        trd_active[obj] <= 1'b1;
                        trd_start       <= 1'b1;
                        trd_start_id    <= obj;
                        trd_start_pc    <= pc;
                    end
                end
                TC_KILL: begin
                    if (obj != BOOT_ID) trd_active[obj] <= 1'b0;
                end
                TC_HALT: begin
                    if (self != BOOT_ID) trd_active[self] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU result or load data, drives the
// register-file write port, stalls on data-cache load misses and
// forwards thread-control ops to the thread-activity table.
// Ports:
//   *_wb inputs   registered bundle from the memory stage
//   d_rd_data, d_miss, d_rdy   data-cache return path
//   rf_wr_*       register-file write port (combinational)
//   stall_wb      upstream freeze (combinational)
//   trd_active, trd_start*     thread table outputs
//   retire_cnt    retired-instruction counter
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        ins_wb,
    input  logic [31:0]        pc_wb,
    input  logic [31:0]        exe_data_wb,
    input  logic [TRD_W-1:0]   trd_wb,
    input  logic [4:0]         reg_wr_wb,
    input  logic               wr_en_wb,
    input  logic               wb_sel_wb,
    input  logic [1:0]         trd_ctrl_wb,
    input  logic [TRD_W-1:0]   obj_trd_wb,
    input  logic [31:0]        d_rd_data,
    input  logic               d_miss,
    input  logic               d_rdy,
    output logic               rf_wr_en,
    output logic [TRD_W-1:0]   rf_wr_trd,
    output logic [4:0]         rf_wr_addr,
    output logic [31:0]        rf_wr_data,
    output logic               stall_wb,
    output logic [NUM_TRD-1:0] trd_active,
    output logic               trd_start,
    output logic [TRD_W-1:0]   trd_start_id,
    output logic [31:0]        trd_start_pc,
    output logic [31:0]        retire_cnt
);

    wb_state_t        state, state_nxt;
    logic [TRD_W-1:0] hold_trd;
    logic [4:0]       hold_addr;
    logic             hold_en;
    logic             capture;
    logic             retire;
    trd_ctrl_t        tc_op;
    logic             valid;

    // PC travels with the instruction for debug visibility only.
    logic unused_pc;
    assign unused_pc = ^pc_wb;

    assign valid = (ins_wb != 32'd0);

    // State, miss hold registers and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            hold_trd   <= '0;
            hold_addr  <= '0;
            hold_en    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_trd  <= trd_wb;
                hold_addr <= reg_wr_wb;
                hold_en   <= wr_en_wb;
            end
            if (retire) retire_cnt <= retire_cnt + 32'd1;
        end
    end

    // Next state, write-port mux, stall and thread-control qualification.
    always_comb begin
        state_nxt  = state;
        rf_wr_en   = 1'b0;
        rf_wr_trd  = trd_wb;
        rf_wr_addr = reg_wr_wb;
        rf_wr_data = wb_sel_wb ? d_rd_data : exe_data_wb;
        stall_wb   = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        tc_op      = TC_NONE;
        case (state)
            RUN: begin
                if (valid && wb_sel_wb && d_miss) begin
                    capture   = 1'b1;
                    stall_wb  = 1'b1;
                    state_nxt = MISS_WAIT;
                end else begin
                    rf_wr_en = valid && wr_en_wb && (reg_wr_wb != 5'd0);
                    retire   = valid;
                    if (valid && !wb_sel_wb) tc_op = trd_ctrl_t'(trd_ctrl_wb);
                end
            end
            MISS_WAIT: begin
                // Upstream inputs belong to the next instruction; use held fields.
                stall_wb   = 1'b1;
                rf_wr_trd  = hold_trd;
                rf_wr_addr = hold_addr;
                rf_wr_data = d_rd_data;
                if (d_rdy) begin
                    rf_wr_en  = hold_en && (hold_addr != 5'd0);
                    retire    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!rst_n) begin
            rf_wr_en = 1'b0;
            stall_wb = 1'b0;
        end
    end

    wb_stage_trd_table u_trd_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (tc_op),
        .obj          (obj_trd_wb),
        .self         (trd_wb),
        .pc           (exe_data_wb),
        .trd_active   (trd_active),
        .trd_start    (trd_start),
        .trd_start_id (trd_start_id),
        .trd_start_pc (trd_start_pc)
    );

endmodule
